lcd_msg_driver: RTL and testbench

Responder end of the FSM-to-LCD message handshake used by the vending machine controller. Accepts a one-cycle `start` plus message fields (item, qty, price, msg_index), formats two 16-character lines, and writes them to an HD44780-compatible character LCD over an 8-bit write-only bus. Pulses `done` when the last character is written. Owns power-up initialisation of the panel.

---
 rtl/lcd_msg_pkg.sv | 38 +++
 rtl/price_bcd.sv | 36 +++
 rtl/lcd_msg_driver.sv | 135 +++++++++++++
 tb/tb_lcd_msg_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_msg_pkg.sv
// lcd_msg_pkg: shared LCD command codes, default timings, message ROMs and character selection.
package lcd_msg_pkg;
  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;
  localparam int T_PWRUP_DEF = 750000;
  localparam int T_SETUP_DEF = 2;
  localparam int T_EN_DEF    = 12;
  localparam int T_CMD_DEF   = 2000;
  localparam int T_CLR_DEF   = 82000;
  localparam logic [127:0] BLANK = {16{8'h20}};
  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_CAPTURE, S_MSG, S_DONE} state_e;
  typedef enum logic [1:0] {W_SETUP, W_EN_HI, W_HOLD, W_WAIT} wr_e;
  function automatic logic [39:0] item_name(input logic [1:0] item);
    return item == 2'd1 ? "Pepsi" : item == 2'd2 ? "lays " : item == 2'd3 ? "Coke " : "-----";
  endfunction
  function automatic logic [127:0] line2_rom(input logic [3:0] msg);
    return msg == 4'd2 ? "Collect item    " : msg == 4'd3 ? "Sold out        " :
           msg == 4'd4 ? "Insufficient    " : BLANK;
  endfunction
  function automatic logic [7:0] char_at(input logic line2, input logic [3:0] pos, input logic [1:0] item,
                                         input logic [2:0] qty, input logic [11:0] bcd, input logic [3:0] msg);
    logic [7:0] h, t, o;
    logic [39:0] tail;
    logic [127:0] s;
    h = {4'h3, bcd[11:8]};
    t = {4'h3, bcd[7:4]};
    o = {4'h3, bcd[3:0]};
    // price digits left-justified with leading zeros dropped
    tail = bcd[11:8] != 4'd0 ? {h, t, o, 16'h2020} : bcd[7:4] != 4'd0 ? {t, o, 24'h202020} : {o, 32'h20202020};
    s = line2 ? (msg == 4'd1 ? {"Qty: ", 5'b00110, qty, {10{8'h20}}} : line2_rom(msg))
              : (msg == 4'd0 ? BLANK : msg <= 4'd4 ? {item_name(item), " = Rs.", tail} : "Invalid msg     ");
    return s[{~pos, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/price_bcd.sv
// price_bcd: sequential 8-bit binary to 3-digit BCD double-dabble, one bit per cycle.
module price_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        valid_o,
  output logic [11:0] bcd_o
);
  logic [19:0] sh_q, adj;
  logic [3:0] cnt_q;
  logic valid_q;
  function automatic logic [3:0] add3(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
  assign adj = {add3(sh_q[19:16]), add3(sh_q[15:12]), add3(sh_q[11:8]), sh_q[7:0]};
  assign bcd_o = sh_q[19:8];
  assign valid_o = valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      sh_q <= {12'd0, bin_i};
      cnt_q <= 4'd8;
      valid_q <= 1'b0;
    end else begin
      valid_q <= cnt_q == 4'd1;
      if (cnt_q != 4'd0) begin
        sh_q <= {adj[18:0], 1'b0};
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end
endmodule

// File: rtl/lcd_msg_driver.sv
// lcd_msg_driver: formats two 16-char lines from message fields and writes them to an HD44780 panel, owning its init.
module lcd_msg_driver
  import lcd_msg_pkg::*;
#(
  parameter int T_PWRUP = T_PWRUP_DEF,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_EN    = T_EN_DEF,
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_CLR   = T_CLR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] item,
  input  logic [2:0] qty,
  input  logic [7:0] price,
  input  logic [3:0] msg_index,
  output logic       done,
  output logic       busy,
  output logic [7:0] lcd,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);
  localparam int TM1 = T_PWRUP > T_CLR ? T_PWRUP : T_CLR;
  localparam int TM2 = TM1 > T_CMD ? TM1 : T_CMD;
  localparam int TM3 = TM2 > T_EN ? TM2 : T_EN;
  localparam int TMAX = TM3 > T_SETUP ? TM3 : T_SETUP;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] C_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] C_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] C_CLR   = CW'(T_CLR - 1);
  state_e state_q;
  wr_e ws_q;
  logic [CW-1:0] cnt_q, wait_cur;
  logic [5:0] widx_q, n_idx;
  logic [7:0] lcd_q, nbyte;
  logic rs_q, en_q, done_q, busy_q, pend_q, capn_q;
  logic [1:0] item_q;
  logic [2:0] qty_q;
  logic [3:0] msg_q, pos;
  logic [11:0] bcd_q, bcd_w;
  logic is_init, st_pend, cap, last, ld, nrs, bcd_v;
  assign lcd = lcd_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_en = en_q;
  assign done = done_q;
  assign busy = busy_q;
  price_bcd u_bcd (.clk(clk), .rst_n(rst), .start_i(cap), .bin_i(price), .valid_o(bcd_v), .bcd_o(bcd_w));
  always_comb begin
    is_init = state_q == S_PWRUP || state_q == S_INIT;
    st_pend = start && is_init && !pend_q;
    cap = state_q == S_CAPTURE || capn_q;
    n_idx = (state_q == S_INIT || state_q == S_MSG) ? widx_q + 6'd1 : 6'd0;
    pos = n_idx >= 6'd19 ? 4'(n_idx - 6'd19) : 4'(n_idx - 6'd2);
    nbyte = is_init ? (n_idx == 6'd4 ? DISP_ON : n_idx == 6'd5 ? ENTRY : n_idx == 6'd6 ? CLEAR : FUNC_SET)
          : n_idx == 6'd0 ? CLEAR : n_idx == 6'd1 ? LINE1 : n_idx == 6'd18 ? LINE2
          : char_at(n_idx >= 6'd19, pos, item_q, qty_q, bcd_q, msg_q);
    nrs = !is_init && n_idx != 6'd0 && n_idx != 6'd1 && n_idx != 6'd18;
    wait_cur = (is_init ? (widx_q < 6'd2 || widx_q == 6'd6) : widx_q == 6'd0) ? C_CLR : C_CMD;
    last = widx_q == (is_init ? 6'd6 : 6'd34);
    ld = (state_q == S_PWRUP && cnt_q == '0) || (state_q == S_IDLE && pend_q) || state_q == S_CAPTURE ||
         ((state_q == S_INIT || state_q == S_MSG) && ws_q == W_WAIT && cnt_q == '0 && !last);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_PWRUP;
      ws_q <= W_SETUP;
      cnt_q <= C_PWRUP;
      widx_q <= '0;
      lcd_q <= '0;
      rs_q <= 1'b0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b1;
      pend_q <= 1'b0;
      capn_q <= 1'b0;
      item_q <= '0;
      qty_q <= '0;
      msg_q <= '0;
      bcd_q <= '0;
    end else begin
      done_q <= 1'b0;
      capn_q <= st_pend;
      if (st_pend) pend_q <= 1'b1;
      if (cap) begin
        item_q <= item;
        qty_q <= qty;
        msg_q <= msg_index;
      end
      if (bcd_v) bcd_q <= bcd_w;
      case (state_q)
        S_PWRUP: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= S_INIT;
        end
        S_IDLE: begin
          if (pend_q) begin
            state_q <= S_MSG;
            pend_q <= 1'b0;
          end else if (start) begin
            state_q <= S_CAPTURE;
            busy_q <= 1'b1;
          end
        end
        S_CAPTURE: state_q <= S_MSG;
        S_DONE: state_q <= S_IDLE;
        default: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else case (ws_q)
            W_SETUP: begin ws_q <= W_EN_HI; en_q <= 1'b1; cnt_q <= C_EN; end
            W_EN_HI: begin ws_q <= W_HOLD; en_q <= 1'b0; cnt_q <= C_SETUP; end
            W_HOLD: begin ws_q <= W_WAIT; cnt_q <= wait_cur; end
            default: if (last) begin
              state_q <= state_q == S_INIT ? S_IDLE : S_DONE;
              done_q <= state_q == S_MSG;
              // a request latched during init keeps busy high straight into its message
              busy_q <= state_q == S_INIT && (pend_q || st_pend);
            end
          endcase
        end
      endcase
      if (ld) begin
        widx_q <= n_idx;
        lcd_q <= nbyte;
        rs_q <= nrs;
        ws_q <= W_SETUP;
        cnt_q <= C_SETUP;
      end
    end
  end
endmodule

// File: tb/tb_lcd_msg_driver.sv
// tb_lcd_msg_driver: scoreboard bench; stimulus queues expected LCD writes, a monitor checks each enable pulse.
module tb_lcd_msg_driver;
  localparam int TP = 20, TS = 1, TE = 2, TC = 4, TL = 8;
  localparam int LAT = 2 + 35 * (2 * TS + TE) + TL + 34 * TC;
  logic clk = 0, rst = 0, start = 0;
  logic [1:0] item = 0;
  logic [2:0] qty = 0;
  logic [7:0] price = 0;
  logic [3:0] msg_index = 0;
  logic done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd;
  int ncmp = 0, nerr = 0;
  logic [8:0] sb[$];
  int dq[$];
  logic [7:0] ib[7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
  string sp16 = "                ";
  logic ep = 0, dp = 0;
  logic [8:0] dprev = 0, expw;
  int stab = 0, wl = 0;

  lcd_msg_driver #(.T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_CMD(TC), .T_CLR(TL)) dut (
    .clk(clk), .rst(rst), .start(start), .item(item), .qty(qty), .price(price), .msg_index(msg_index),
    .done(done), .busy(busy), .lcd(lcd), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en));

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic push_init();
    foreach (ib[i]) sb.push_back({1'b0, ib[i]});
  endtask

  task automatic push_msg(input string l1, input string l2);
    sb.push_back(9'h001);
    sb.push_back(9'h080);
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, l1[i]});
    sb.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, l2[i]});
    dq.push_back(1);
  endtask

  // monitor: every rising lcd_en pops one expected write; every done pops one expected message
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      ep = 0; dp = 0; stab = 0; wl = 0;
    end else begin
      stab = ({lcd_rs, lcd} == dprev) ? stab + 1 : 0;
      if (lcd_en && !ep) begin
        chk("setup_stable", int'(stab >= TS), 1);
        chk("rw_low", lcd_rw, 0);
        if (sb.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL unexpected_write: got %h expected none", {lcd_rs, lcd});
        end else begin
          expw = sb.pop_front();
          chk("write", {lcd_rs, lcd}, expw);
        end
        wl = 1;
      end else if (lcd_en) begin
        wl++;
        if (stab == 0) begin
          ncmp++; nerr++;
          $display("FAIL data_during_en: got %h expected %h", {lcd_rs, lcd}, dprev);
        end
      end
      if (!lcd_en && ep) chk("en_width", wl, TE);
      if (done) begin
        chk("done_busy", busy, 0);
        chk("done_width", dp, 0);
        chk("done_expected", int'(dq.size() > 0), 1);
        chk("done_writes_left", sb.size(), 0);
        if (dq.size() > 0) void'(dq.pop_front());
      end
      ep = lcd_en;
      dp = done;
    end
    dprev = {lcd_rs, lcd};
  end

  task automatic wait_init(input string nm);
    int n = 0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_writes_left"}, sb.size(), 0);
  endtask

  task automatic run_msg(input logic [1:0] it, input logic [2:0] q, input logic [7:0] p, input logic [3:0] m,
                         input string l1, input string l2, input bit intr);
    int n = 0;
    push_msg(l1, l2);
    @(negedge clk);
    item = it; qty = q; price = p; msg_index = m; start = 1;
    while (n < 3 * LAT && !done) begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 0;
      if (n == 2) begin item = ~it; qty = ~q; price = ~p; msg_index = ~m; end
      if (intr && n == 100) start = 1;
      if (intr && n == 101) start = 0;
    end
    chk("latency", n, LAT);
    if (intr) begin
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (LAT) @(posedge clk);
      #1;
      chk("no_second_msg", sb.size() + dq.size(), 0);
      chk("idle_after_busy_start", busy, 0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    bit dropped;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lcd", lcd, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_en", lcd_en, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    push_init();
    rst = 1;
    n = 0;
    while (!lcd_en && n < 200) begin @(posedge clk); #1; n++; end
    chk("pwrup_delay", n, TP + TS);
    chk("busy_in_init", busy, 1);
    wait_init("init1");

    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    push_init();
    push_msg("Pepsi = Rs.15   ", "Qty: 5          ");
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    item = 1; qty = 5; price = 15; msg_index = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    item = 2; qty = 0; price = 200; msg_index = 3;
    n = 0;
    dropped = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1; n++;
      if (!busy && !done) dropped = 1;
    end
    chk("pend_done", done, 1);
    chk("pend_busy_held", dropped, 0);
    @(posedge clk); #1;

    run_msg(2, 3, 16, 1, "lays  = Rs.16   ", "Qty: 3          ", 0);
    run_msg(3, 0, 0, 2, "Coke  = Rs.0    ", "Collect item    ", 0);
    run_msg(0, 1, 255, 3, "----- = Rs.255  ", "Sold out        ", 1);
    run_msg(1, 2, 100, 4, "Pepsi = Rs.100  ", "Insufficient    ", 0);
    run_msg(2, 4, 42, 0, sp16, sp16, 0);
    run_msg(2, 6, 7, 9, "Invalid msg     ", sp16, 0);

    push_msg("Coke  = Rs.99   ", "Qty: 7          ");
    @(negedge clk);
    item = 3; qty = 7; price = 99; msg_index = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (50) @(posedge clk);
    #1;
    n = 0;
    while (!lcd_en && n < 100) begin @(posedge clk); #1; n++; end
    chk("en_before_reset", lcd_en, 1);
    rst = 0;
    #1;
    chk("midrst_en", lcd_en, 0);
    chk("midrst_lcd", lcd, 0);
    chk("midrst_rs", lcd_rs, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_done", done, 0);
    sb.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    push_init();
    rst = 1;
    wait_init("init2");
    run_msg(3, 7, 99, 1, "Coke  = Rs.99   ", "Qty: 7          ", 0);
    chk("final_queues", sb.size() + dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
